// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-sizing helper for the single-clock FIFO.
package fifo_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_LENGTH = 8;

    // One extra pointer bit distinguishes a full buffer from an empty one.
    function automatic int ptr_width(input int length);
        return $clog2(length) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// LENGTH x WIDTH register array with one synchronous write port and a
// registered read port that holds its value between accepted reads.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int LENGTH = DEFAULT_LENGTH,
    parameter int ADDR_W = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [WIDTH-1:0]  read_data
);

    logic [WIDTH-1:0] mem [LENGTH];

    // Storage is never cleared; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    // Reading the same slot that is being written returns the old word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data <= '0;
        end else if (read_en) begin
            read_data <= mem[read_addr];
        end
    end

endmodule

// File: rtl/fifo.sv
// Synchronous single-clock FIFO: pointer bookkeeping, accept logic and
// full/empty decode around a fifo_mem storage array.
module fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int LENGTH = DEFAULT_LENGTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             write_en,
    input  logic             read_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);

    localparam int ADDR_W = $clog2(LENGTH);
    localparam int PTR_W  = ptr_width(LENGTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             read_ok;
    logic             write_ok;

    // Flags come straight from the pointer registers; the wrap bit separates full from empty.
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
        read_ok  = read_en && !empty;
        write_ok = write_en && (!full || read_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (write_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk        (clk),
        .reset_n    (reset_n),
        .write_en   (write_ok),
        .write_addr (wr_ptr[ADDR_W-1:0]),
        .write_data (data_in),
        .read_en    (read_ok),
        .read_addr  (rd_ptr[ADDR_W-1:0]),
        .read_data  (data_out)
    );

endmodule

// File: tb/tb_fifo.sv
// Directed and randomized checks of the FIFO against a queue-based model of
// its occupancy and popped data.
module tb_fifo;

    localparam int WIDTH  = 16;
    localparam int LENGTH = 8;

    logic             clk      = 1'b0;
    logic             reset_n  = 1'b0;
    logic             write_en = 1'b0;
    logic             read_en  = 1'b0;
    logic [WIDTH-1:0] data_in  = '0;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] data_out;

    int total  = 0;
    int passed = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] model_dout = '0;

    fifo #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .write_en (write_en),
        .read_en  (read_en),
        .data_in  (data_in),
        .full     (full),
        .empty    (empty),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [WIDTH-1:0] obs,
                                input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        check_output({tag, "_empty"}, WIDTH'(empty), WIDTH'(model_q.size() == 0));
        check_output({tag, "_full"}, WIDTH'(full), WIDTH'(model_q.size() == LENGTH));
        check_output({tag, "_dout"}, data_out, model_dout);
    endtask

    // One clock of stimulus: drive on the falling edge, update the model on
    // the rising edge, compare shortly after.
    task automatic apply_stimulus(input logic we, input logic re,
                                  input logic [WIDTH-1:0] din, input string tag);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        write_en = we;
        read_en  = re;
        data_in  = din;
        @(posedge clk);
        rd_ok = re && (model_q.size() > 0);
        wr_ok = we && ((model_q.size() < LENGTH) || rd_ok);
        if (rd_ok) model_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(din);
        #1;
        check_model(tag);
    endtask

    initial begin
        int pw;
        int pr;
        logic [WIDTH-1:0] held;

        #2;
        check_output("reset_empty", WIDTH'(empty), WIDTH'(1));
        check_output("reset_full", WIDTH'(full), WIDTH'(0));
        check_output("reset_dout", data_out, '0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, '0, "idle0");
        apply_stimulus(1'b0, 1'b0, '0, "idle1");

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b0, WIDTH'(16'h1111 * (i + 1)), "wr5");
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1, '0, "rd3");
            check_output("rd3_const", data_out, WIDTH'(16'h1111 * (i + 1)));
        end

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, WIDTH'(16'h6666 + 16'h1111 * i), "wr4");
        end
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, 1'b1, '0, "drain6");
            check_output("drain6_const", data_out, WIDTH'(16'h4444 + 16'h1111 * i));
        end
        check_output("drained_empty", WIDTH'(empty), WIDTH'(1));
        apply_stimulus(1'b0, 1'b1, '0, "rd_empty");
        check_output("rd_empty_hold", data_out, 16'h9999);

        for (int i = 0; i < LENGTH; i++) begin
            apply_stimulus(1'b1, 1'b0, WIDTH'(16'hA000 + i), "fill");
        end
        check_output("fill_full", WIDTH'(full), WIDTH'(1));
        apply_stimulus(1'b1, 1'b0, 16'hDEAD, "wr_full");
        for (int i = 0; i < LENGTH; i++) begin
            apply_stimulus(1'b0, 1'b1, '0, "drain8");
            check_output("drain8_const", data_out, WIDTH'(16'hA000 + i));
        end
        check_output("drain8_empty", WIDTH'(empty), WIDTH'(1));

        for (int i = 0; i < LENGTH; i++) begin
            apply_stimulus(1'b1, 1'b0, WIDTH'(16'hB000 + i), "fill2");
        end
        apply_stimulus(1'b1, 1'b1, 16'hBEEF, "wr_rd_full");
        check_output("wr_rd_full_dout", data_out, 16'hB000);
        check_output("wr_rd_full_flag", WIDTH'(full), WIDTH'(1));
        for (int i = 0; i < LENGTH; i++) begin
            apply_stimulus(1'b0, 1'b1, '0, "drain_beef");
        end
        check_output("beef_last", data_out, 16'hBEEF);

        apply_stimulus(1'b1, 1'b1, 16'hC0DE, "wr_rd_empty");
        check_output("wr_rd_empty_dout", data_out, 16'hBEEF);
        check_output("wr_rd_empty_flag", WIDTH'(empty), WIDTH'(0));
        apply_stimulus(1'b1, 1'b0, 16'hC0DF, "pre_rst");
        apply_stimulus(1'b1, 1'b1, 16'hC0E0, "pre_rst");
        apply_stimulus(1'b1, 1'b0, 16'hC0E1, "pre_rst");
        apply_stimulus(1'b0, 1'b0, '0, "pre_rst_idle");

        // Reset lands mid-cycle, well away from either clock edge.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_q.delete();
        model_dout = '0;
        check_output("async_rst_empty", WIDTH'(empty), WIDTH'(1));
        check_output("async_rst_full", WIDTH'(full), WIDTH'(0));
        check_output("async_rst_dout", data_out, '0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(1'b0, 1'b1, '0, "post_rst_rd");

        // Random traffic with shifting write/read bias to visit both full and empty.
        for (int blk = 0; blk < 8; blk++) begin
            pw = blk[0] ? 30 : 75;
            pr = blk[0] ? 75 : 30;
            for (int i = 0; i < 50; i++) begin
                held = WIDTH'($urandom);
                apply_stimulus($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                               held, "rand");
            end
        end
        apply_stimulus(1'b0, 1'b0, '0, "final_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
